// File: rtl/cordic_arbiter.sv
// Round-robin sharing of one pipelined CORDIC cosine unit between requesters A and B.
// A tag pipeline follows each issued operand so its result returns only to its issuer.
module cordic_arbiter #(
    parameter int LATENCY      = 16,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [31:0] a_data,
    output logic        a_res_valid,
    output logic [31:0] a_res_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [31:0] b_data,
    output logic        b_res_valid,
    output logic [31:0] b_res_data,
    output logic [31:0] cordic_in,
    input  logic [31:0] cordic_out,
    output logic        busy
);

    localparam int              CW      = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(MAX_INFLIGHT);
    localparam logic            ID_A    = 1'b0;
    localparam logic            ID_B    = 1'b1;

    logic [CW-1:0]  cnt_a_reg, cnt_a_next;
    logic [CW-1:0]  cnt_b_reg, cnt_b_next;
    logic           last_grant_reg;
    logic [LATENCY:0] tag_valid_reg;
    logic [LATENCY:0] tag_id_reg;

    logic a_req, b_req;
    logic grant_a, grant_b;
    logic a_ret, b_ret;

    always_comb begin
        a_ready = (cnt_a_reg < CNT_MAX);
        b_ready = (cnt_b_reg < CNT_MAX);
        a_req   = a_valid & a_ready;
        b_req   = b_valid & b_ready;
        // On a tie the requester that did not win last time gets the slot.
        grant_a = a_req & (~b_req | (last_grant_reg == ID_B));
        grant_b = b_req & ~grant_a;
        a_ret   = tag_valid_reg[LATENCY] & (tag_id_reg[LATENCY] == ID_A);
        b_ret   = tag_valid_reg[LATENCY] & (tag_id_reg[LATENCY] == ID_B);
        busy    = (|tag_valid_reg) | (cnt_a_reg != '0) | (cnt_b_reg != '0);
    end

    always_comb begin
        cnt_a_next = cnt_a_reg;
        case ({grant_a, a_ret})
            2'b10:   cnt_a_next = cnt_a_reg + 1'b1;
            2'b01:   cnt_a_next = cnt_a_reg - 1'b1;
            default: cnt_a_next = cnt_a_reg;
        endcase
        cnt_b_next = cnt_b_reg;
        case ({grant_b, b_ret})
            2'b10:   cnt_b_next = cnt_b_reg + 1'b1;
            2'b01:   cnt_b_next = cnt_b_reg - 1'b1;
            default: cnt_b_next = cnt_b_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_a_reg      <= '0;
            cnt_b_reg      <= '0;
            last_grant_reg <= ID_B;
            cordic_in      <= '0;
            tag_valid_reg  <= '0;
            tag_id_reg     <= '0;
            a_res_valid    <= 1'b0;
            b_res_valid    <= 1'b0;
            a_res_data     <= '0;
            b_res_data     <= '0;
        end else begin
            cnt_a_reg <= cnt_a_next;
            cnt_b_reg <= cnt_b_next;
            if (grant_a) begin
                last_grant_reg <= ID_A;
                cordic_in      <= a_data;
            end else if (grant_b) begin
                last_grant_reg <= ID_B;
                cordic_in      <= b_data;
            end
            // Stage LATENCY lines up with the CORDIC output for that operand.
            tag_valid_reg <= {tag_valid_reg[LATENCY-1:0], grant_a | grant_b};
            tag_id_reg    <= {tag_id_reg[LATENCY-1:0], grant_b};
            a_res_valid   <= a_ret;
            b_res_valid   <= b_ret;
            if (a_ret) a_res_data <= cordic_out;
            if (b_ret) b_res_data <= cordic_out;
        end
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(a_ret && !grant_a && cnt_a_reg == '0));
    b_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(b_ret && !grant_b && cnt_b_reg == '0));

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter: two instances (roomy cap and cap of 2), each fed
// by a behavioural CORDIC pipeline that returns a cosine table lookup LATENCY cycles later.
module tb_cordic_arbiter;

    localparam int L = 4;
    localparam logic [31:0] ONE  = 32'h3f800000;
    localparam logic [31:0] ZERO = 32'h00000000;
    localparam logic [31:0] COS1 = 32'h3f0a5140;
    localparam logic [31:0] COS0 = 32'h3f800000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [31:0] a_data = '0, b_data = '0;

    logic        a_ready1, b_ready1, a_res_valid1, b_res_valid1, busy1;
    logic [31:0] a_res_data1, b_res_data1, cordic_in1, cordic_out1;
    logic        a_ready2, b_ready2, a_res_valid2, b_res_valid2, busy2;
    logic [31:0] a_res_data2, b_res_data2, cordic_in2, cordic_out2;

    logic [31:0] pipe1 [0:L-1];
    logic [31:0] pipe2 [0:L-1];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] cos_model(input logic [31:0] x);
        case (x)
            32'h3f800000: cos_model = 32'h3f0a5140;
            32'h00000000: cos_model = 32'h3f800000;
            default:      cos_model = x ^ 32'h5a5a5a5a;
        endcase
    endfunction

    always @(posedge clk) begin
        pipe1[0] <= cordic_in1;
        pipe2[0] <= cordic_in2;
        for (int i = 1; i < L; i++) begin
            pipe1[i] <= pipe1[i-1];
            pipe2[i] <= pipe2[i-1];
        end
    end
    assign cordic_out1 = cos_model(pipe1[L-1]);
    assign cordic_out2 = cos_model(pipe2[L-1]);

    cordic_arbiter #(.LATENCY(L), .MAX_INFLIGHT(6)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready1), .a_data(a_data),
        .a_res_valid(a_res_valid1), .a_res_data(a_res_data1),
        .b_valid(b_valid), .b_ready(b_ready1), .b_data(b_data),
        .b_res_valid(b_res_valid1), .b_res_data(b_res_data1),
        .cordic_in(cordic_in1), .cordic_out(cordic_out1), .busy(busy1)
    );

    cordic_arbiter #(.LATENCY(L), .MAX_INFLIGHT(2)) dut2 (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready2), .a_data(a_data),
        .a_res_valid(a_res_valid2), .a_res_data(a_res_data2),
        .b_valid(b_valid), .b_ready(b_ready2), .b_data(b_data),
        .b_res_valid(b_res_valid2), .b_res_data(b_res_data2),
        .cordic_in(cordic_in2), .cordic_out(cordic_out2), .busy(busy2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        step();
        step();
        @(negedge clk);
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        n_tests++; if ({a_res_valid1, b_res_valid1, busy1, a_ready1, b_ready1} !== 5'b00011) begin
            n_fail++; $display("FAIL reset_flags1: got %b expected 00011", {a_res_valid1, b_res_valid1, busy1, a_ready1, b_ready1}); end
        n_tests++; if ({cordic_in1, a_res_data1, b_res_data1} !== 96'h0) begin
            n_fail++; $display("FAIL reset_data1: got %h expected 0", {cordic_in1, a_res_data1, b_res_data1}); end
        n_tests++; if ({a_res_valid2, b_res_valid2, busy2, a_ready2, b_ready2} !== 5'b00011) begin
            n_fail++; $display("FAIL reset_flags2: got %b expected 00011", {a_res_valid2, b_res_valid2, busy2, a_ready2, b_ready2}); end
        n_tests++; if ({cordic_in2, a_res_data2, b_res_data2} !== 96'h0) begin
            n_fail++; $display("FAIL reset_data2: got %h expected 0", {cordic_in2, a_res_data2, b_res_data2}); end
        apply_reset();
        n_tests++; if ({busy1, a_ready1, b_ready1, a_res_valid1, b_res_valid1} !== 5'b01100) begin
            n_fail++; $display("FAIL reset_release: got %b expected 01100", {busy1, a_ready1, b_ready1, a_res_valid1, b_res_valid1}); end
        $display("[TB] reset checked");
    endtask

    task automatic test_single_op();
        apply_reset();
        a_data  = ONE;
        a_valid = 1'b1;
        n_tests++; if (a_ready1 !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b expected 1", a_ready1); end
        step();
        a_valid = 1'b0;
        n_tests++; if (cordic_in1 !== ONE) begin n_fail++; $display("FAIL single_issue: got %h expected %h", cordic_in1, ONE); end
        n_tests++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy1); end
        for (int c = 1; c <= 8; c++) begin
            step();
            n_tests++; if (a_res_valid1 !== (c == 5)) begin
                n_fail++; $display("FAIL single_res_valid c=%0d: got %b expected %b", c, a_res_valid1, (c == 5)); end
            n_tests++; if (b_res_valid1 !== 1'b0) begin
                n_fail++; $display("FAIL single_b_quiet c=%0d: got %b expected 0", c, b_res_valid1); end
            if (c == 5) begin
                $display("[TB] single op result %h", a_res_data1);
                n_tests++; if (a_res_data1 !== COS1) begin n_fail++; $display("FAIL single_res_data: got %h expected %h", a_res_data1, COS1); end
                n_tests++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b expected 0", busy1); end
            end
        end
    endtask

    task automatic test_alternation();
        logic exp_a, exp_b;
        apply_reset();
        a_data = ONE;
        b_data = ZERO;
        for (int c = 0; c <= 14; c++) begin
            a_valid = (c < 8);
            b_valid = (c < 8);
            step();
            if (c < 8) begin
                n_tests++; if (cordic_in1 !== ((c % 2 == 0) ? ONE : ZERO)) begin
                    n_fail++; $display("FAIL alt_grant c=%0d: got %h expected %h", c, cordic_in1, (c % 2 == 0) ? ONE : ZERO); end
            end
            exp_a = (c >= 5) && (c <= 11) && (c % 2 == 1);
            exp_b = (c >= 6) && (c <= 12) && (c % 2 == 0);
            n_tests++; if ({a_res_valid1, b_res_valid1} !== {exp_a, exp_b}) begin
                n_fail++; $display("FAIL alt_res_order c=%0d: got %b expected %b", c, {a_res_valid1, b_res_valid1}, {exp_a, exp_b}); end
            if (exp_a) begin
                $display("[TB] alt A result c=%0d %h", c, a_res_data1);
                n_tests++; if (a_res_data1 !== COS1) begin n_fail++; $display("FAIL alt_a_data c=%0d: got %h expected %h", c, a_res_data1, COS1); end
            end
            if (exp_b) begin
                $display("[TB] alt B result c=%0d %h", c, b_res_data1);
                n_tests++; if (b_res_data1 !== COS0) begin n_fail++; $display("FAIL alt_b_data c=%0d: got %h expected %h", c, b_res_data1, COS0); end
            end
        end
    endtask

    task automatic test_cap();
        logic exp_rdy, exp_res;
        apply_reset();
        a_data = ONE;
        for (int c = 0; c <= 20; c++) begin
            a_valid = (c <= 17);
            step();
            exp_rdy = (c >= 17) || (c % 6 == 0) || (c % 6 == 5);
            exp_res = (c >= 5) && (c <= 18) && ((c % 6 == 5) || (c % 6 == 0));
            n_tests++; if (a_ready2 !== exp_rdy) begin
                n_fail++; $display("FAIL cap_ready c=%0d: got %b expected %b", c, a_ready2, exp_rdy); end
            n_tests++; if (a_res_valid2 !== exp_res) begin
                n_fail++; $display("FAIL cap_res c=%0d: got %b expected %b", c, a_res_valid2, exp_res); end
            if (exp_res) $display("[TB] cap A result c=%0d %h", c, a_res_data2);
        end
    endtask

    task automatic test_starvation();
        logic [31:0] exp_ci;
        apply_reset();
        a_data = ONE;
        b_data = ZERO;
        for (int c = 0; c <= 9; c++) begin
            a_valid = (c <= 4);
            b_valid = (c == 2) || (c == 3);
            if (b_valid) begin
                n_tests++; if (b_ready2 !== 1'b1) begin
                    n_fail++; $display("FAIL starve_b_ready c=%0d: got %b expected 1", c, b_ready2); end
            end
            step();
            exp_ci = (c <= 1) ? ONE : ZERO;
            n_tests++; if (cordic_in2 !== exp_ci) begin
                n_fail++; $display("FAIL starve_issue c=%0d: got %h expected %h", c, cordic_in2, exp_ci); end
            n_tests++; if (a_ready2 !== ((c == 0) || (c >= 5))) begin
                n_fail++; $display("FAIL starve_a_ready c=%0d: got %b expected %b", c, a_ready2, (c == 0) || (c >= 5)); end
            n_tests++; if (b_ready2 !== ((c <= 2) || (c >= 7))) begin
                n_fail++; $display("FAIL starve_b_cap c=%0d: got %b expected %b", c, b_ready2, (c <= 2) || (c >= 7)); end
            n_tests++; if ({a_res_valid2, b_res_valid2} !== {(c == 5) || (c == 6), (c == 7) || (c == 8)}) begin
                n_fail++; $display("FAIL starve_res c=%0d: got %b expected %b", c, {a_res_valid2, b_res_valid2},
                                   {(c == 5) || (c == 6), (c == 7) || (c == 8)}); end
            if (b_res_valid2) $display("[TB] starve B result c=%0d %h", c, b_res_data2);
        end
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        a_data = ONE;
        b_data = ZERO;
        for (int c = 0; c <= 6; c++) begin
            a_valid = (c <= 4);
            b_valid = (c <= 4);
            step();
        end
        n_tests++; if ({b_res_valid1, busy1} !== 2'b11) begin
            n_fail++; $display("FAIL mid_pre_state: got %b expected 11", {b_res_valid1, busy1}); end
        n_tests++; if ({a_res_data1, b_res_data1} !== {COS1, COS0}) begin
            n_fail++; $display("FAIL mid_pre_data: got %h expected %h", {a_res_data1, b_res_data1}, {COS1, COS0}); end
        #2 reset_n = 1'b0;
        #1;
        $display("[TB] reset asserted mid-flight");
        n_tests++; if ({a_res_valid1, b_res_valid1, busy1, a_ready1, b_ready1} !== 5'b00011) begin
            n_fail++; $display("FAIL mid_reset_flags: got %b expected 00011", {a_res_valid1, b_res_valid1, busy1, a_ready1, b_ready1}); end
        n_tests++; if ({cordic_in1, a_res_data1, b_res_data1} !== 96'h0) begin
            n_fail++; $display("FAIL mid_reset_data: got %h expected 0", {cordic_in1, a_res_data1, b_res_data1}); end
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            n_tests++; if ({a_res_valid1, b_res_valid1, busy1} !== 3'b000) begin
                n_fail++; $display("FAIL mid_post c=%0d: got %b expected 000", c, {a_res_valid1, b_res_valid1, busy1}); end
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        a_data  = ONE;
        a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        n_tests++; if (a_ready2 !== 1'b1) begin n_fail++; $display("FAIL simul_first: got %b expected 1", a_ready2); end
        repeat (4) step();
        a_data  = ZERO;
        a_valid = 1'b1;
        step();
        $display("[TB] simultaneous accept/return result %h", a_res_data2);
        n_tests++; if ({a_res_valid2, busy2, a_ready2} !== 3'b111) begin
            n_fail++; $display("FAIL simul_edge: got %b expected 111", {a_res_valid2, busy2, a_ready2}); end
        n_tests++; if (a_res_data2 !== COS1) begin n_fail++; $display("FAIL simul_data: got %h expected %h", a_res_data2, COS1); end
        step();
        a_valid = 1'b0;
        n_tests++; if (a_ready2 !== 1'b0) begin n_fail++; $display("FAIL simul_cap: got %b expected 0", a_ready2); end
        for (int c = 7; c <= 11; c++) begin
            step();
            n_tests++; if (busy2 !== (c <= 10)) begin
                n_fail++; $display("FAIL simul_busy c=%0d: got %b expected %b", c, busy2, (c <= 10)); end
            n_tests++; if (a_res_valid2 !== (c >= 10)) begin
                n_fail++; $display("FAIL simul_res c=%0d: got %b expected %b", c, a_res_valid2, (c >= 10)); end
            if (c == 10) begin
                n_tests++; if (a_res_data2 !== COS0) begin n_fail++; $display("FAIL simul_data2: got %h expected %h", a_res_data2, COS0); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_alternation();
        test_cap();
        test_starvation();
        test_reset_midflight();
        test_simultaneous();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_arbiter.md
# cordic_arbiter

Shares one fully pipelined `cordic_stage_multi_stage_latency` cosine unit between two requesters (A and B) that each submit IEEE-754 single-precision operands. It sits between the requesters and the CORDIC pipeline. It arbitrates round-robin at one issue per cycle and tracks every in-flight operation with a tag pipeline matched to the CORDIC latency. It returns each result only to the requester that issued it, and caps outstanding operations per requester.

## Interface
Parameters:
- `LATENCY`, 16: cycles from a change on `cordic_in` to the matching value on `cordic_out`. Must match the instantiated CORDIC `NUM_STAGES` configuration. Range 1..64.
- `MAX_INFLIGHT`, 8: maximum outstanding operations per requester. Range 1..LATENCY+2.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `a_valid` in 1: requester A offers `a_data`.
- `a_ready` out 1: A may issue.
- `a_data` in 32: A operand, float.
- `a_res_valid` out 1: one-cycle pulse, `a_res_data` valid. No backpressure.
- `a_res_data` out 32: A result, float.
- `b_valid`, `b_ready`, `b_data`, `b_res_valid`, `b_res_data`: identical to the A ports, for requester B.
- `cordic_in` out 32: registered operand to the CORDIC `float_in`.
- `cordic_out` in 32: from the CORDIC `float_out`.
- `busy` out 1: high while any operation is in flight.

## Operation
- Outstanding counters:
  - `cnt_a` and `cnt_b` are each `$clog2(MAX_INFLIGHT+1)` bits wide.
  - `x_ready = (cnt_x < MAX_INFLIGHT)`. This is combinational from registers only, with no dependence on `x_valid`.
- Request and accept:
  - `x_req = x_valid & x_ready`.
  - A transfer (accept) occurs on an edge where `x_req` is high and x is granted.
- Arbiter:
  - At most one grant per cycle.
  - If only one requester has `x_req`, grant it.
  - If both do, grant the one not granted most recently.
  - `last_grant` updates only on a grant. It resets to B, so A wins the first tie.
- Issue on an accepted edge:
  - `cordic_in <= granted data`.
  - Tag stage 0 `<= {1, id}`, with id A=0 and B=1.
- With no grant:
  - Tag stage 0 valid `<= 0`.
  - `cordic_in` holds its previous value. The CORDIC keeps computing, but no tag follows it.
- Tag pipeline:
  - LATENCY+1 stages of {valid, id}, shifting every cycle unconditionally.
  - Stage LATENCY aligns with `cordic_out`.
- Return on every edge:
  - `x_res_valid <= stage[LATENCY].valid & (id==x)`.
  - `x_res_data <= cordic_out` when that holds.
  - `x_res_data` otherwise holds its value.
  - At most one of `a_res_valid` and `b_res_valid` is high in any cycle.
- Counter updates:
  - Accept only: +1.
  - Result edge only (the edge that sets `x_res_valid`): −1.
  - Both on the same edge: unchanged.
  - Counters never overflow because `x_ready` gates accepts. Underflow is impossible by construction; assert on it in simulation.
- `busy = |{stage valids} | (cnt_a != 0) | (cnt_b != 0)`.
- Reset mid-operation:
  - All tags are cleared and all in-flight results are discarded silently.
  - No `res_valid` pulse follows reset deassertion until new accepts have traversed the pipeline.

## Timing
- Reset values:
  - `cordic_in` = 0.
  - All tag stages invalid.
  - `cnt_a` = `cnt_b` = 0.
  - `last_grant` = B.
  - `a_res_valid` = `b_res_valid` = 0.
  - `a_res_data` = `b_res_data` = 0.
  - `busy` = 0.
  - `a_ready` = `b_ready` = 1.
- Latency: an accept at edge E0 produces `x_res_valid` high for exactly the cycle after edge E0+LATENCY+1.
- Throughput: one issue per cycle total. With both requesters continuously valid and not capped, grants alternate A, B, A, B…
- Cap:
  - With `cnt_x == MAX_INFLIGHT`, `x_ready` is low.
  - `x_ready` rises the cycle after the result edge that decrements the counter.
  - An accept on the edge after that is legal.
- `res_data` is registered. There are no combinational paths from `cordic_out` or any `x_valid` to any output.

## Test plan
- Single op:
  - Stimulus: after reset, `a_data=0x3f800000` (1.0) for one cycle.
  - Required: `a_res_valid` pulses exactly LATENCY+1 edges after accept, and `a_res_data` equals the bench CORDIC model's cos(1.0) (≈0x3f0a5140, within model tolerance). `b_res_valid` never rises.
- Tie and alternation:
  - Stimulus: A and B both valid for 8 cycles, A data 0x3f800000 and B data 0x00000000.
  - Required: grants are A,B,A,B,A,B,A,B. Results return in the same order, with B results equal to cos(0) ≈ 0x3f800000.
- Cap with MAX_INFLIGHT=2 and B idle:
  - Stimulus: A held valid.
  - Required: exactly 2 accepts, then `a_ready`=0 until the first result. Steady state is 2 accepts per LATENCY+2 cycles.
- Starvation-free under cap:
  - Stimulus: A capped and B valid.
  - Required: B is accepted every cycle A is not ready, and B is never blocked by A.
- Reset mid-flight:
  - Stimulus: issue 5 ops, then assert `reset_n`=0 asynchronously mid-cycle.
  - Required: all outputs immediately take their reset values. After release, no `res_valid` appears for LATENCY+2 cycles, and `busy`=0.
- Simultaneous accept and return:
  - Stimulus: with `cnt_a=1`, a new A accept lands on the same edge as A's result.
  - Required: `cnt_a` stays 1 and `busy` stays 1.
